// File: rtl/clk_edge_monitor.sv
// Synchronizes an external slow clock into clk, emits rise/fall strobes, measures the period
// and flags clock loss. Optional glitch filter: define CLK_EDGE_MONITOR_GLITCH_FILTER_EN.
module clk_edge_monitor #(
    parameter int CNT_W   = 18,
    parameter int TIMEOUT = 200000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_in,
    output logic             clk_sync,
    output logic             rise_p,
    output logic             fall_p,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             clk_lost
);

    typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic             r_valid;
    logic             r_lost;
    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_rise;
    logic             w_fall;
    logic             w_level;
    logic             w_period_ld;
    logic             w_timeout;
    logic             w_arm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= clk_in;
            r_s2 <= r_s1;
        end
    end

`ifdef CLK_EDGE_MONITOR_GLITCH_FILTER_EN
    logic r_f1;
    logic r_f2;
    logic r_f3;
    logic r_filt;

    // Filtered level only moves once three consecutive samples agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f1   <= 1'b0;
            r_f2   <= 1'b0;
            r_f3   <= 1'b0;
            r_filt <= 1'b0;
        end else begin
            r_f1   <= r_s2;
            r_f2   <= r_f1;
            r_f3   <= r_f2;
            r_filt <= w_level;
        end
    end

    assign w_level  = (r_f1 == r_f2 && r_f2 == r_f3) ? r_f3 : r_filt;
    assign w_rise   = w_level & ~r_filt;
    assign w_fall   = ~w_level & r_filt;
    assign clk_sync = r_filt;
`else
    logic r_s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s3 <= 1'b0;
        end else begin
            r_s3 <= r_s2;
        end
    end

    assign w_level  = r_s2;
    assign w_rise   = w_level & ~r_s3;
    assign w_fall   = ~w_level & r_s3;
    assign clk_sync = r_s2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_rise;
            r_fall <= w_fall;
        end
    end

    // Counts cycles since the last detected rise; saturates instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An edge in the timeout cycle takes priority, so the timeout branch sits under else.
    always_comb begin
        w_state_nxt = r_state;
        w_period_ld = 1'b0;
        w_timeout   = 1'b0;
        w_arm       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ARMED;
                    w_arm       = 1'b1;
                end
            end
            ARMED, LOCKED: begin
                if (w_rise) begin
                    w_state_nxt = LOCKED;
                    w_period_ld = 1'b1;
                end else if (r_cnt == TO_LAST) begin
                    w_state_nxt = IDLE;
                    w_timeout   = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period <= '0;
            r_valid  <= 1'b0;
            r_lost   <= 1'b0;
        end else begin
            if (w_period_ld) begin
                r_period <= r_cnt + 1'b1;
                r_valid  <= 1'b1;
            end else if (w_timeout) begin
                r_valid  <= 1'b0;
            end
            if (w_timeout) begin
                r_lost <= 1'b1;
            end else if (w_arm) begin
                r_lost <= 1'b0;
            end
        end
    end

    assign rise_p       = r_rise;
    assign fall_p       = r_fall;
    assign period       = r_period;
    assign period_valid = r_valid;
    assign clk_lost     = r_lost;

endmodule

// File: tb/tb_clk_edge_monitor.sv
// Self-checking bench for clk_edge_monitor: timestamp-based reference model plus directed and random stimulus.
module tb_clk_edge_monitor;

    localparam int CNT_W   = 18;
    localparam int TIMEOUT = 50;
`ifdef CLK_EDGE_MONITOR_GLITCH_FILTER_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clk_in = 1'b0;
    logic             clk_sync;
    logic             rise_p;
    logic             fall_p;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             clk_lost;

    int n_cmp  = 0;
    int n_fail = 0;

    clk_edge_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_in       (clk_in),
        .clk_sync     (clk_sync),
        .rise_p       (rise_p),
        .fall_p       (fall_p),
        .period       (period),
        .period_valid (period_valid),
        .clk_lost     (clk_lost)
    );

    always #5 clk = ~clk;

    // Reference model: sample history, detected level, timestamps of rising edges.
    logic             h [0:5];
    logic             m_lvl;
    logic             m_sync;
    logic             m_rise;
    logic             m_fall;
    logic             m_lost;
    logic [CNT_W-1:0] m_period;
    int               m_edges;
    longint           m_n;
    longint           m_last_rise;
    logic             m_old;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) h[i] = 1'b0;
            m_lvl = 1'b0; m_sync = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
            m_lost = 1'b0; m_period = '0; m_edges = 0; m_n = 0; m_last_rise = 0;
        end else begin
            for (int i = 5; i > 0; i--) h[i] = h[i-1];
            h[0] = clk_in;
            m_n++;
            m_old = m_lvl;
`ifdef CLK_EDGE_MONITOR_GLITCH_FILTER_EN
            if (h[3] == h[4] && h[4] == h[5]) m_lvl = h[3];
            m_sync = m_lvl;
`else
            m_lvl  = h[2];
            m_sync = h[1];
`endif
            m_rise = m_lvl & ~m_old;
            m_fall = ~m_lvl & m_old;
            if (m_rise) begin
                if (m_edges == 0) begin
                    m_lost  = 1'b0;
                    m_edges = 1;
                end else begin
                    m_period = CNT_W'(m_n - m_last_rise);
                    m_edges  = 2;
                end
                m_last_rise = m_n;
            end else if (m_edges > 0 && (m_n - m_last_rise) == TIMEOUT) begin
                m_lost  = 1'b1;
                m_edges = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            n_cmp++;
            if ({clk_sync, rise_p, fall_p, period_valid, clk_lost, period} !==
                {m_sync, m_rise, m_fall, (m_edges == 2), m_lost, m_period}) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t: dut sync=%b rise=%b fall=%b valid=%b lost=%b period=%0d ; expected sync=%b rise=%b fall=%b valid=%b lost=%b period=%0d",
                         $time, clk_sync, rise_p, fall_p, period_valid, clk_lost, period,
                         m_sync, m_rise, m_fall, (m_edges == 2), m_lost, m_period);
            end
        end
    end

    // Event monitor: latency of strobes and distance from last rise_p to clk_lost.
    longint cyc = 0;
    longint drv_rise_cyc = 0;
    longint drv_fall_cyc = 0;
    longint last_rp_cyc = 0;
    longint rise_lat = -1;
    longint fall_lat = -1;
    longint lost_delta = -1;
    int     n_rise_seen = 0;
    int     n_fall_seen = 0;
    logic   lost_q = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rise_p) begin
            rise_lat    = cyc - drv_rise_cyc;
            last_rp_cyc = cyc;
            n_rise_seen++;
        end
        if (fall_p) begin
            fall_lat = cyc - drv_fall_cyc;
            n_fall_seen++;
        end
        if (clk_lost && !lost_q) lost_delta = cyc - last_rp_cyc;
        lost_q = clk_lost;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic v);
        @(posedge clk);
        #2;
        if (v && !clk_in) drv_rise_cyc = cyc;
        if (!v && clk_in) drv_fall_cyc = cyc;
        clk_in = v;
    endtask

    task automatic run(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < hi; i++) step(1'b1);
            for (int i = 0; i < lo; i++) step(1'b0);
        end
    endtask

    int r;
    int base_r;
    int base_f;

    initial begin
        rst = 1'b1;
        clk_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {clk_sync, rise_p, fall_p, period_valid, clk_lost, period}, 0);
        @(posedge clk);
        #2 rst = 1'b0;

        run(5, 5, 1);
        check("first_rise_latency", rise_lat, LAT);
        check("first_rise_valid", period_valid, 0);
        check("first_rise_period", period, 0);

        run(5, 5, 5);
        check("steady_period", period, 10);
        check("steady_valid", period_valid, 1);
        check("steady_rise_latency", rise_lat, LAT);
        check("steady_fall_latency", fall_lat, LAT);
        check("steady_not_lost", clk_lost, 0);

        run(5, 5, 2);
        step(1'b1);
        step(1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrun_reset_outputs", {clk_sync, rise_p, fall_p, period_valid, clk_lost, period}, 0);
        clk_in = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        run(5, 5, 1);
        check("after_reset_valid", period_valid, 0);
        check("after_reset_period", period, 0);
        run(5, 5, 3);
        check("after_reset_relock", period, 10);

        run(8, 8, 4);
        check("freq_change_period", period, 16);
        run(5, 5, 3);
        check("freq_back_period", period, 10);

        run(0, 80, 1);
        check("loss_flag", clk_lost, 1);
        check("loss_valid", period_valid, 0);
        check("loss_period_held", period, 10);
        check("loss_delay", lost_delta, TIMEOUT);
        run(5, 5, 1);
        check("restart_lost_cleared", clk_lost, 0);
        check("restart_valid_low", period_valid, 0);
        run(5, 5, 1);
        check("restart_valid_back", period_valid, 1);

        run(25, 25, 4);
        check("boundary_not_lost", clk_lost, 0);
        check("boundary_period", period, TIMEOUT);
        check("boundary_valid", period_valid, 1);
        run(0, 60, 1);

`ifdef CLK_EDGE_MONITOR_GLITCH_FILTER_EN
        base_r = n_rise_seen;
        step(1'b1);
        run(0, 10, 1);
        run(2, 10, 1);
        check("glitch_rejected", n_rise_seen - base_r, 0);
        base_r = n_rise_seen;
        base_f = n_fall_seen;
        run(3, 12, 1);
        check("pulse3_rises", n_rise_seen - base_r, 1);
        check("pulse3_falls", n_fall_seen - base_f, 1);
        check("pulse3_rise_latency", rise_lat, 6);
        check("pulse3_fall_latency", fall_lat, 6);
`else
        base_r = n_rise_seen;
        base_f = n_fall_seen;
        run(2, 10, 1);
        check("short_pulse_rises", n_rise_seen - base_r, 1);
        check("short_pulse_falls", n_fall_seen - base_f, 1);
`endif

        for (int s = 0; s < 400; s++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                @(posedge clk);
                #2 rst = 1'b1;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #2 rst = 1'b0;
            end else if (r < 8) begin
                run(0, int'($urandom_range(40, 70)), 1);
            end else if (r < 12) begin
                run(25, 25, 1);
            end else begin
                run(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)), 1);
            end
        end
        run(0, 10, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
